dcache_data_sched: RTL and testbench

Port scheduler for one data-cache way's line-wide data RAM, the single-ported 8-word-per-line store with byte-enable store writes and full-line refill writes. Shares the one RAM port among four requesters: CPU loads, CPU stores (via a one-entry store buffer), line refills and victim writeback reads. Grants at most one operation per cycle, drives the RAM control/data pins, and routes registered read data back to the owning requester.

---
 rtl/dcache_data_sched.sv | 246 ++++++++++++++++++++++++
 tb/tb_dcache_data_sched.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcache_data_sched.sv
// Single-port data-RAM scheduler for one dcache way: arbitrates refill, writeback, store-buffer drain and loads.
// Optional store-to-load forwarding is enabled by defining DCACHE_STORE_FWD_EN.
module dcache_data_sched #(
    parameter int ADDR_WIDTH = 10,
    parameter int STARVE_MAX = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  ld_req,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    output logic                  ld_gnt,
    output logic                  ld_rvalid,
    output logic [31:0]           ld_rdata,

    input  logic                  st_req,
    input  logic [ADDR_WIDTH-1:0] st_addr,
    input  logic [31:0]           st_data,
    input  logic [3:0]            st_ben,
    output logic                  st_rdy,

    input  logic                  rf_req,
    input  logic [ADDR_WIDTH-1:0] rf_addr,
    input  logic [255:0]          rf_line,
    output logic                  rf_gnt,

    input  logic                  wb_req,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    output logic                  wb_gnt,
    output logic                  wb_rvalid,
    output logic [255:0]          wb_line,

    output logic [ADDR_WIDTH-1:0] bram_raddr,
    output logic [ADDR_WIDTH-1:0] bram_waddr,
    output logic                  bram_re,
    output logic                  bram_we,
    output logic                  bram_store,
    output logic                  bram_hit_write,
    output logic [31:0]           bram_din,
    output logic [3:0]            bram_byte_ben,
    output logic [255:0]          bram_din_all,

    input  logic [31:0]           bram_dout,
    input  logic [255:0]          bram_dout_all
);

    // A line holds 8 words of 4 bytes, so conflicts compare everything above the word field.
    localparam int LINE_LSB = 5;
    localparam int CW       = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_LOAD,
        OWN_WB
    } owner_e;

    typedef enum logic [2:0] {
        OP_IDLE,
        OP_REFILL,
        OP_WB,
        OP_DRAIN,
        OP_LOAD
    } op_e;

    logic                  sb_valid_q, sb_valid_d;
    logic [ADDR_WIDTH-1:0] sb_addr_q, sb_addr_d;
    logic [31:0]           sb_data_q, sb_data_d;
    logic [3:0]            sb_ben_q, sb_ben_d;
    logic [CW-1:0]         wait_q, wait_d;
    owner_e                owner_q, owner_d;

    op_e  op;
    logic rf_conf, wb_conf, ld_conf;
    logic starved, ld_block, force_drain, drain_now;

    assign rf_conf = sb_valid_q && (sb_addr_q[ADDR_WIDTH-1:LINE_LSB] == rf_addr[ADDR_WIDTH-1:LINE_LSB]);
    assign wb_conf = sb_valid_q && (sb_addr_q[ADDR_WIDTH-1:LINE_LSB] == wb_addr[ADDR_WIDTH-1:LINE_LSB]);
    assign ld_conf = sb_valid_q && (sb_addr_q[ADDR_WIDTH-1:LINE_LSB] == ld_addr[ADDR_WIDTH-1:LINE_LSB]);
    assign starved = (wait_q >= CW'(STARVE_MAX));

`ifdef DCACHE_STORE_FWD_EN
    assign ld_block = 1'b0;
`else
    assign ld_block = ld_req && ld_conf;
`endif

    assign force_drain = sb_valid_q &&
                         (starved || (rf_req && rf_conf) || (wb_req && wb_conf) || ld_block);

    // Reset suppresses every grant so nothing reaches the RAM while state is being cleared.
    always_comb begin
        op = OP_IDLE;
        if (rst) begin
            op = OP_IDLE;
        end else if (rf_req && !rf_conf) begin
            op = OP_REFILL;
        end else if (wb_req && !wb_conf) begin
            op = OP_WB;
        end else if (force_drain) begin
            op = OP_DRAIN;
        end else if (ld_req) begin
            op = OP_LOAD;
        end else if (sb_valid_q) begin
            op = OP_DRAIN;
        end
    end

    assign drain_now = (op == OP_DRAIN);
    assign st_rdy    = !sb_valid_q || drain_now;

    always_comb begin
        ld_gnt         = 1'b0;
        rf_gnt         = 1'b0;
        wb_gnt         = 1'b0;
        bram_re        = 1'b0;
        bram_we        = 1'b0;
        bram_store     = 1'b0;
        bram_hit_write = 1'b0;
        bram_raddr     = '0;
        bram_waddr     = '0;
        bram_din       = '0;
        bram_byte_ben  = '0;
        bram_din_all   = '0;
        case (op)
            OP_REFILL: begin
                rf_gnt         = 1'b1;
                bram_we        = 1'b1;
                bram_hit_write = 1'b1;
                bram_waddr     = rf_addr;
                bram_din_all   = rf_line;
            end
            OP_WB: begin
                wb_gnt     = 1'b1;
                bram_re    = 1'b1;
                bram_raddr = wb_addr;
            end
            OP_DRAIN: begin
                bram_we       = 1'b1;
                bram_store    = 1'b1;
                bram_waddr    = sb_addr_q;
                bram_din      = sb_data_q;
                bram_byte_ben = sb_ben_q;
            end
            OP_LOAD: begin
                ld_gnt     = 1'b1;
                bram_re    = 1'b1;
                bram_raddr = ld_addr;
            end
            default: ;
        endcase
    end

    always_comb begin
        sb_valid_d = sb_valid_q;
        sb_addr_d  = sb_addr_q;
        sb_data_d  = sb_data_q;
        sb_ben_d   = sb_ben_q;
        wait_d     = wait_q;
        owner_d    = OWN_NONE;

        if (drain_now) begin
            sb_valid_d = 1'b0;
        end
        if (st_req && st_rdy) begin
            sb_valid_d = 1'b1;
            sb_addr_d  = st_addr;
            sb_data_d  = st_data;
            sb_ben_d   = st_ben;
        end

        // A freshly loaded entry starts its wait from zero, even when it replaces a draining one.
        if (!sb_valid_q || drain_now) begin
            wait_d = '0;
        end else if (!starved) begin
            wait_d = wait_q + CW'(1);
        end

        case (op)
            OP_LOAD: owner_d = OWN_LOAD;
            OP_WB:   owner_d = OWN_WB;
            default: owner_d = OWN_NONE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sb_valid_q <= 1'b0;
            sb_addr_q  <= '0;
            sb_data_q  <= '0;
            sb_ben_q   <= '0;
            wait_q     <= '0;
            owner_q    <= OWN_NONE;
        end else begin
            sb_valid_q <= sb_valid_d;
            sb_addr_q  <= sb_addr_d;
            sb_data_q  <= sb_data_d;
            sb_ben_q   <= sb_ben_d;
            wait_q     <= wait_d;
            owner_q    <= owner_d;
        end
    end

    assign ld_rvalid = (owner_q == OWN_LOAD) && !rst;
    assign wb_rvalid = (owner_q == OWN_WB) && !rst;
    assign wb_line   = wb_rvalid ? bram_dout_all : '0;

`ifdef DCACHE_STORE_FWD_EN
    logic        fwd_hit_q, fwd_hit_d;
    logic [31:0] fwd_data_q, fwd_data_d;
    logic [3:0]  fwd_ben_q, fwd_ben_d;

    // Snapshot the buffered store at grant time; it may drain before the response cycle.
    always_comb begin
        fwd_hit_d  = (op == OP_LOAD) && ld_conf && (sb_addr_q[4:2] == ld_addr[4:2]);
        fwd_data_d = sb_data_q;
        fwd_ben_d  = sb_ben_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fwd_hit_q  <= 1'b0;
            fwd_data_q <= '0;
            fwd_ben_q  <= '0;
        end else begin
            fwd_hit_q  <= fwd_hit_d;
            fwd_data_q <= fwd_data_d;
            fwd_ben_q  <= fwd_ben_d;
        end
    end

    always_comb begin
        ld_rdata = '0;
        if (ld_rvalid) begin
            ld_rdata = bram_dout;
            for (int unsigned b = 0; b < 4; b++) begin
                if (fwd_hit_q && fwd_ben_q[b]) begin
                    ld_rdata[8*b +: 8] = fwd_data_q[8*b +: 8];
                end
            end
        end
    end
`else
    assign ld_rdata = ld_rvalid ? bram_dout : '0;
`endif

endmodule

// File: tb/tb_dcache_data_sched.sv
// Directed bench for dcache_data_sched: a behavioural RAM, stimulus with inline grant checks,
// and a scoreboard monitor for load/writeback responses.
module tb_dcache_data_sched;

    localparam int AW = 10;

    logic          clk = 1'b0;
    logic          rst;
    logic          ld_req, ld_gnt, ld_rvalid;
    logic [AW-1:0] ld_addr;
    logic [31:0]   ld_rdata;
    logic          st_req, st_rdy;
    logic [AW-1:0] st_addr;
    logic [31:0]   st_data;
    logic [3:0]    st_ben;
    logic          rf_req, rf_gnt;
    logic [AW-1:0] rf_addr;
    logic [255:0]  rf_line;
    logic          wb_req, wb_gnt, wb_rvalid;
    logic [AW-1:0] wb_addr;
    logic [255:0]  wb_line;
    logic [AW-1:0] bram_raddr, bram_waddr;
    logic          bram_re, bram_we, bram_store, bram_hit_write;
    logic [31:0]   bram_din, bram_dout;
    logic [3:0]    bram_byte_ben;
    logic [255:0]  bram_din_all, bram_dout_all;

    always #5 clk = ~clk;

    dcache_data_sched #(.ADDR_WIDTH(AW), .STARVE_MAX(4)) dut (
        .clk(clk), .rst(rst),
        .ld_req(ld_req), .ld_addr(ld_addr), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_ben(st_ben), .st_rdy(st_rdy),
        .rf_req(rf_req), .rf_addr(rf_addr), .rf_line(rf_line), .rf_gnt(rf_gnt),
        .wb_req(wb_req), .wb_addr(wb_addr), .wb_gnt(wb_gnt), .wb_rvalid(wb_rvalid), .wb_line(wb_line),
        .bram_raddr(bram_raddr), .bram_waddr(bram_waddr), .bram_re(bram_re), .bram_we(bram_we),
        .bram_store(bram_store), .bram_hit_write(bram_hit_write), .bram_din(bram_din),
        .bram_byte_ben(bram_byte_ben), .bram_din_all(bram_din_all),
        .bram_dout(bram_dout), .bram_dout_all(bram_dout_all)
    );

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pat(input int l, input int w);
        return 32'hA000_0000 | 32'(l << 8) | 32'(w);
    endfunction

    function automatic logic [255:0] pline(input int l);
        logic [255:0] v;
        for (int w = 0; w < 8; w++) v[32*w +: 32] = pat(l, w);
        return v;
    endfunction

    // Behavioural single-port RAM with registered read data; reset reloads a known pattern.
    logic [31:0] mem [32][8];

    always @(posedge clk) begin
        if (rst) begin
            for (int l = 0; l < 32; l++)
                for (int w = 0; w < 8; w++) mem[l][w] <= pat(l, w);
            bram_dout     <= '0;
            bram_dout_all <= '0;
        end else begin
            if (bram_re) begin
                bram_dout <= mem[bram_raddr[9:5]][bram_raddr[4:2]];
                for (int w = 0; w < 8; w++) bram_dout_all[32*w +: 32] <= mem[bram_raddr[9:5]][w];
            end
            if (bram_we && bram_hit_write)
                for (int w = 0; w < 8; w++) mem[bram_waddr[9:5]][w] <= bram_din_all[32*w +: 32];
            if (bram_we && bram_store)
                for (int b = 0; b < 4; b++)
                    if (bram_byte_ben[b]) mem[bram_waddr[9:5]][bram_waddr[4:2]][8*b +: 8] <= bram_din[8*b +: 8];
        end
    end

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct { logic [31:0]  data; int due; } ld_exp_t;
    typedef struct { logic [255:0] data; int due; } wb_exp_t;
    ld_exp_t ld_q[$];
    wb_exp_t wb_q[$];
    ld_exp_t ld_e;
    wb_exp_t wb_e;

    task automatic push_ld(input logic [31:0] d);
        ld_q.push_back('{data: d, due: cyc + 1});
    endtask

    // Scoreboard monitor: every response must match the head of its queue in data and arrival cycle.
    always @(negedge clk) begin
        if (ld_rvalid) begin
            if (ld_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL ld_unexpected: got rvalid data %0h expected no response", ld_rdata);
            end else begin
                ld_e = ld_q.pop_front();
                chk("ld_rdata", ld_rdata, ld_e.data);
                chk("ld_rvalid_cycle", cyc, ld_e.due);
            end
        end
        if (wb_rvalid) begin
            if (wb_q.size() == 0) begin
                checks++; failures++;
                $display("FAIL wb_unexpected: got rvalid line %0h expected no response", wb_line);
            end else begin
                wb_e = wb_q.pop_front();
                chk("wb_line", wb_line, wb_e.data);
                chk("wb_rvalid_cycle", cyc, wb_e.due);
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    logic [255:0] rfl, wbl;

    initial begin
        rst = 1'b1;
        ld_req = 0; ld_addr = '0; st_req = 0; st_addr = '0; st_data = '0; st_ben = '0;
        rf_req = 0; rf_addr = '0; rf_line = '0; wb_req = 0; wb_addr = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Reset state
        @(negedge clk);
        chk("rst_ld_gnt", ld_gnt, 0);
        chk("rst_rf_gnt", rf_gnt, 0);
        chk("rst_wb_gnt", wb_gnt, 0);
        chk("rst_ld_rvalid", ld_rvalid, 0);
        chk("rst_wb_rvalid", wb_rvalid, 0);
        chk("rst_ld_rdata", ld_rdata, 0);
        chk("rst_wb_line", wb_line, 0);
        chk("rst_st_rdy", st_rdy, 1);
        chk("rst_bram_we", bram_we, 0);
        chk("rst_bram_re", bram_re, 0);
        nxt();

        // Store to an idle port drains next cycle, then a load sees it
        st_req = 1; st_addr = 10'h040; st_data = 32'h1122_3344; st_ben = 4'hF;
        @(negedge clk);
        chk("t1_st_rdy", st_rdy, 1);
        chk("t1_accept_no_we", bram_we, 0);
        nxt(); st_req = 0;
        @(negedge clk);
        chk("t1_drain_store", bram_store, 1);
        chk("t1_drain_we", bram_we, 1);
        chk("t1_drain_hitw", bram_hit_write, 0);
        chk("t1_drain_waddr", bram_waddr, 10'h040);
        chk("t1_drain_din", bram_din, 32'h1122_3344);
        chk("t1_drain_ben", bram_byte_ben, 4'hF);
        nxt(); ld_req = 1; ld_addr = 10'h040;
        @(negedge clk);
        chk("t1_ld_gnt", ld_gnt, 1);
        push_ld(32'h1122_3344);
        nxt(); ld_req = 0;

        // Refill beats a load to another line
        for (int w = 0; w < 8; w++) rfl[32*w +: 32] = 32'h5000_0000 | 32'(w);
        rfl[31:0] = 32'hAABB_CCDD;
        rf_req = 1; rf_addr = 10'h0A0; rf_line = rfl; ld_req = 1; ld_addr = 10'h100;
        @(negedge clk);
        chk("t2_rf_gnt", rf_gnt, 1);
        chk("t2_ld_wait", ld_gnt, 0);
        chk("t2_hit_write", bram_hit_write, 1);
        chk("t2_rf_store", bram_store, 0);
        chk("t2_rf_waddr", bram_waddr, 10'h0A0);
        chk("t2_rf_din_all", bram_din_all, rfl);
        nxt(); rf_req = 0;
        @(negedge clk);
        chk("t2_ld_gnt", ld_gnt, 1);
        push_ld(pat(8, 0));
        nxt(); ld_addr = 10'h0A4;
        @(negedge clk);
        chk("t2_ld_refilled_gnt", ld_gnt, 1);
        push_ld(32'h5000_0001);
        nxt(); ld_req = 0;

        // Writeback to the buffered store's line forces a drain first
        st_req = 1; st_addr = 10'h040; st_data = 32'hCAFE_F00D; st_ben = 4'hF;
        nxt(); st_req = 0; wb_req = 1; wb_addr = 10'h040;
        @(negedge clk);
        chk("t3_wb_wait", wb_gnt, 0);
        chk("t3_forced_drain", bram_store, 1);
        nxt();
        @(negedge clk);
        chk("t3_wb_gnt", wb_gnt, 1);
        wbl = pline(2);
        wbl[31:0] = 32'hCAFE_F00D;
        wb_q.push_back('{data: wbl, due: cyc + 1});
        nxt(); wb_req = 0;

        // Continuous loads starve the buffer until the wait counter saturates
        st_req = 1; st_addr = 10'h300; st_data = 32'h0BAD_BEEF; st_ben = 4'hC;
        ld_req = 1; ld_addr = 10'h200;
        @(negedge clk);
        chk("t4_ld_gnt0", ld_gnt, 1);
        push_ld(pat(16, 0));
        nxt(); st_req = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("t4_ld_gnt_wait", ld_gnt, 1);
            chk("t4_no_drain", bram_store, 0);
            push_ld(pat(16, 0));
            nxt();
        end
        st_req = 1; st_addr = 10'h304; st_data = 32'h1234_5678; st_ben = 4'h1;
        @(negedge clk);
        chk("t4_starve_ld_blocked", ld_gnt, 0);
        chk("t4_starve_drain", bram_store, 1);
        chk("t4_starve_waddr", bram_waddr, 10'h300);
        chk("t4_reload_rdy", st_rdy, 1);
        nxt(); st_req = 0;
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk);
            chk("t4_ld_gnt_rewait", ld_gnt, 1);
            chk("t4_no_drain2", bram_store, 0);
            push_ld(pat(16, 0));
            nxt();
        end
        @(negedge clk);
        chk("t4_counter_restart_drain", bram_store, 1);
        chk("t4_drain2_waddr", bram_waddr, 10'h304);
        nxt();
        @(negedge clk);
        chk("t4_ld_resume", ld_gnt, 1);
        push_ld(pat(16, 0));
        nxt(); ld_addr = 10'h300;
        @(negedge clk);
        chk("t4_ld300_gnt", ld_gnt, 1);
        push_ld(32'h0BAD_1800);
        nxt(); ld_addr = 10'h304;
        @(negedge clk);
        chk("t4_ld304_gnt", ld_gnt, 1);
        push_ld(32'hA000_1878);
        nxt(); ld_req = 0;

        // Load to the same word as a partial buffered store
        st_req = 1; st_addr = 10'h0A0; st_data = 32'h0000_1234; st_ben = 4'h3;
        nxt(); st_req = 0; ld_req = 1; ld_addr = 10'h0A0;
`ifdef DCACHE_STORE_FWD_EN
        @(negedge clk);
        chk("t5_fwd_ld_gnt", ld_gnt, 1);
        chk("t5_fwd_no_drain", bram_store, 0);
        push_ld(32'hAABB_1234);
        nxt(); ld_req = 0;
        @(negedge clk);
        chk("t5_fwd_idle_drain", bram_store, 1);
        nxt();
`else
        @(negedge clk);
        chk("t5_ld_blocked", ld_gnt, 0);
        chk("t5_conflict_drain", bram_store, 1);
        nxt();
        @(negedge clk);
        chk("t5_ld_after_drain", ld_gnt, 1);
        push_ld(32'hAABB_1234);
        nxt(); ld_req = 0;
`endif
        nxt(); ld_req = 1; ld_addr = 10'h0A0;
        @(negedge clk);
        chk("t5_reload_gnt", ld_gnt, 1);
        push_ld(32'hAABB_1234);
        nxt(); ld_req = 0;

        // Reset the cycle after a load grant discards the response and the buffered store
        ld_req = 1; ld_addr = 10'h200;
        st_req = 1; st_addr = 10'h3E0; st_data = 32'hFFFF_FFFF; st_ben = 4'hF;
        @(negedge clk);
        chk("t6_ld_gnt", ld_gnt, 1);
        nxt(); ld_req = 0; st_req = 0; rst = 1;
        @(negedge clk);
        chk("t6_rst_no_rvalid", ld_rvalid, 0);
        chk("t6_rst_no_we", bram_we, 0);
        nxt(); rst = 0;
        @(negedge clk);
        chk("t6_post_no_rvalid", ld_rvalid, 0);
        chk("t6_post_st_rdy", st_rdy, 1);
        chk("t6_sb_discarded", bram_store, 0);
        nxt(); ld_req = 1; ld_addr = 10'h3E0;
        @(negedge clk);
        chk("t6_ld_gnt2", ld_gnt, 1);
        push_ld(pat(31, 0));
        nxt(); ld_req = 0;

        repeat (3) nxt();
        chk("ld_responses_outstanding", ld_q.size(), 0);
        chk("wb_responses_outstanding", wb_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
